// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer, LSB-first, one bit per clock.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (op_a, op_b accepted in IDLE only)
//   op_a, op_b           WIDTH-bit unsigned operands
//   out_valid/out_ready  result handshake (result held in DONE until taken)
//   result               WIDTH+1-bit sum, MSB is the final carry
//   busy                 high while bits are being shifted through the adder
module serial_add_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] shift_a, shift_b;
    logic [CNT_W-1:0] count;
    logic carry, s1, c1, s, c2, co, last;
    // Two cascaded half adders with the carry fed back from a register.
    assign s1   = shift_a[0] ^ shift_b[0];
    assign c1   = shift_a[0] & shift_b[0];
    assign s    = s1 ^ carry;
    assign c2   = s1 & carry;
    assign co   = c1 | c2;
    assign last = count == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_comb begin
        state_next = (state == IDLE  && in_valid)  ? SHIFT :
                     (state == SHIFT && last)      ? DONE  :
                     (state == DONE  && out_ready) ? IDLE  : state;
    end
    always_comb begin
        in_ready  = state == IDLE;
        busy      = state == SHIFT;
        out_valid = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_a <= '0;
            shift_b <= '0;
            carry   <= 1'b0;
            count   <= '0;
            result  <= '0;
        end else if (state == IDLE && in_valid) begin
            shift_a <= op_a;
            shift_b <= op_b;
            carry   <= 1'b0;
            count   <= '0;
            result  <= '0;
        end else if (state == SHIFT) begin
            shift_a       <= shift_a >> 1;
            shift_b       <= shift_b >> 1;
            carry         <= co;
            count         <= count + CNT_W'(1);
            result[count] <= s;
            // Final carry out of the top bit becomes the result MSB.
            if (last)
                result[WIDTH] <= co;
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed self-checking bench for serial_add_seq.
module tb_serial_add_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] result;
    logic       busy;
    int n_cmp = 0;
    int n_err = 0;
    serial_add_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Called at a negedge in IDLE. Accepts a/b, scrambles (or holds) the inputs
    // during SHIFT, checks latency and busy length, stalls the consumer, then
    // releases it and checks the return to IDLE.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input int stall,
                           input bit keep_valid, input logic [7:0] na, input logic [7:0] nb,
                           input logic [8:0] exp, input string tag);
        int cyc, busy_cyc;
        op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = keep_valid;
        op_a = na; op_b = nb;
        cyc = 0; busy_cyc = 0;
        while (!out_valid && cyc < 50) begin
            if (busy) busy_cyc++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, cyc, 8);
        chk({tag, "_busy_len"}, busy_cyc, 8);
        chk({tag, "_result"}, result, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_ready"}, in_ready, 0);
            chk({tag, "_stall_result"}, result, exp);
        end
        out_ready = 1'b1;
        chk({tag, "_take_ready"}, in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_idle_result"}, result, exp);
    endtask
    initial begin
        int seen, n, viol;
        logic [7:0] a, b;
        // Reset with in_valid asserted: operands must not be taken.
        in_valid = 1'b1; op_a = 8'd7; op_b = 8'd9;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        run_add(8'd3,   8'd5,   0, 1'b0, 8'hC3, 8'h3C, 9'd8,   "basic");
        run_add(8'hFF,  8'h01,  0, 1'b0, 8'h00, 8'h00, 9'h100, "ripple");
        run_add(8'hFF,  8'hFF,  0, 1'b0, 8'h12, 8'h34, 9'h1FE, "max");
        run_add(8'h00,  8'h00,  0, 1'b0, 8'hFF, 8'hFF, 9'h000, "zero");
        run_add(8'd77,  8'd99,  5, 1'b0, 8'h01, 8'h02, 9'd176,  "bp");
        run_add(8'd10,  8'd20,  0, 1'b1, 8'hAA, 8'h55, 9'd30,  "busy_rej");
        run_add(8'hAA,  8'h55,  0, 1'b0, 8'h00, 8'h00, 9'h0FF, "second");
        // Reset in the middle of SHIFT discards the partial sum.
        op_a = 8'd200; op_b = 8'd100; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", seen, 0);
        run_add(8'd1, 8'd1, 0, 1'b0, 8'h00, 8'h00, 9'd2, "after_rst");
        // Back-to-back with both handshakes tied high.
        viol = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            op_a = a; op_b = b;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (in_ready && (busy || out_valid)) viol++;
            end while (!out_valid && n < 50);
            chk("b2b_result", result, {1'b0, a} + {1'b0, b});
            @(negedge clk);
            n++;
            chk("b2b_period", n, 10);
            chk("b2b_idle", in_ready, 1);
        end
        in_valid = 1'b0;
        chk("b2b_ready_overlap", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
